// File: rtl/subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : subtractor_pkg
//  Purpose  : Shared definitions for serial arithmetic controllers: the
//             controller state encoding and a helper that sizes a bit counter
//             able to reach WIDTH without wrapping.
//  Revision : 1.0  initial release
// ============================================================================
package subtractor_pkg;

    // Controller state encoding shared by serial arithmetic sequencers.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed for a counter that counts 0..width inclusive.
    function automatic int cnt_bits(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage : subtractor_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor
//  Purpose  : 1-bit full subtractor cell, a - b - Bin.
//  Ports    : a, b, Bin  - minuend bit, subtrahend bit, borrow-in
//             Difference - result bit
//             Bout       - borrow-out
//  Revision : 1.0  initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic Bin,
    output logic Difference,
    output logic Bout
);

    assign Difference = a ^ b ^ Bin;
    // Borrow when b exceeds a, or when they are equal and a borrow comes in.
    assign Bout       = (~a & b) | (~(a ^ b) & Bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_ctrl
//  Purpose  : Bit-serial WIDTH-bit subtractor. Time-shares one full_subtractor
//             cell LSB-first over WIDTH cycles, holding the borrow in a flop.
//  Ports    : clk, rst_n     - clock, synchronous active-low reset
//             start          - request, sampled only when not busy
//             a, b, bin      - operands and borrow-in, captured on accept
//             busy           - bits are being processed
//             done           - one-cycle pulse, results valid
//             diff,bout,zero - (a-b-bin) mod 2^WIDTH, final borrow, diff==0
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor_ctrl
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CNT_W = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             borrow_q,  borrow_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [WIDTH-1:0] diff_q,    diff_d;
    logic             bout_q,    bout_d;
    logic             zero_q,    zero_d;

    logic             w_cell_diff;
    logic             w_cell_bout;

    full_subtractor u_cell (
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .Bin        (borrow_q),
        .Difference (w_cell_diff),
        .Bout       (w_cell_bout)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        diff_d    = diff_q;
        bout_d    = bout_q;
        zero_d    = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new request directly so start held high
                // yields one operation every WIDTH+1 cycles.
                busy_d = 1'b0;
                if (start) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    borrow_d  = bin;
                    cnt_d     = '0;
                    diff_sh_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Result bits enter at the MSB so that after WIDTH shifts
                // bit 0 of the difference sits at position 0.
                diff_sh_d = (diff_sh_q >> 1) | {w_cell_diff, {(WIDTH-1){1'b0}}};
                borrow_d  = w_cell_bout;
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                cnt_d     = cnt_q + c_cnt_one;
                if (cnt_q == c_last_bit) begin
                    // Publish the fully assembled result on the same edge
                    // that raises done.
                    diff_d  = diff_sh_d;
                    bout_d  = w_cell_bout;
                    zero_d  = (diff_sh_d == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            borrow_q  <= borrow_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
            zero_q    <= zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule : serial_subtractor_ctrl
`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor_ctrl
//  Purpose  : Directed and random self-checking bench for
//             serial_subtractor_ctrl at WIDTH=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             bin_i;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .bin   (bin_i),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation (caller sits just after an edge, DUT idle or done)
    // and check latency and results against the supplied expectations.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cin, input logic [7:0] exp_diff,
                          input logic exp_bout, input logic exp_zero);
        int lat;
        start = 1'b1; a_i = av; b_i = bv; bin_i = cin;
        tick();
        start = 1'b0;
        a_i = 8'($urandom); b_i = 8'($urandom); bin_i = 1'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"},  32'(lat),  32'd8);
        check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check({tag, "_bout"}, 32'(bout), 32'(exp_bout));
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        check({tag, "_nbusy"}, 32'(busy), 32'd0);
    endtask

    logic [7:0] ops_a [4];
    logic [7:0] ops_b [4];
    logic       ops_c [4];

    initial begin
        int ndone, last_cyc, k;
        logic prev_done, prev_busy;
        logic [7:0] ra, rb, ed;
        logic rc, eb;

        rst_n = 1'b0; start = 1'b1; a_i = 8'hAA; b_i = 8'h55; bin_i = 1'b1;

        // Reset held with start asserted: nothing may start.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_diff", 32'(diff), 32'd0);
            check("rst_bout", 32'(bout), 32'd0);
            check("rst_zero", 32'(zero), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        run_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        run_op("op0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("op1010b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("op3737", 8'h37, 8'h37, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        // start pulsed mid-RUN must be ignored.
        start = 1'b1; a_i = 8'h5A; b_i = 8'h3C; bin_i = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; a_i = 8'h11; b_i = 8'h22; bin_i = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                ndone++;
                check("ign_diff", 32'(diff), 32'h1E);
                check("ign_bout", 32'(bout), 32'd0);
            end
            tick();
        end
        check("ign_ndone", 32'(ndone), 32'd1);

        // Back-to-back with start held high; results every 9 cycles.
        ops_a[0] = 8'h80; ops_b[0] = 8'h01; ops_c[0] = 1'b0;  // 7F, 0
        ops_a[1] = 8'h01; ops_b[1] = 8'h02; ops_c[1] = 1'b1;  // FE, 1
        ops_a[2] = 8'hC3; ops_b[2] = 8'h42; ops_c[2] = 1'b1;  // 80, 0
        ops_a[3] = 8'h20; ops_b[3] = 8'h1F; ops_c[3] = 1'b1;  // 00, 0
        start = 1'b1; a_i = ops_a[0]; b_i = ops_b[0]; bin_i = ops_c[0];
        k = 1; ndone = 0; last_cyc = 0; prev_done = 1'b0; prev_busy = 1'b0;
        for (int cyc = 1; cyc <= 60 && ndone < 4; cyc++) begin
            tick();
            if (done) begin
                check("b2b_dbl", 32'(prev_done), 32'd0);
                case (ndone)
                    0: begin check("b2b0_diff", 32'(diff), 32'h7F); check("b2b0_bout", 32'(bout), 32'd0); end
                    1: begin check("b2b1_diff", 32'(diff), 32'hFE); check("b2b1_bout", 32'(bout), 32'd1); end
                    2: begin check("b2b2_diff", 32'(diff), 32'h80); check("b2b2_bout", 32'(bout), 32'd0); end
                    default: begin check("b2b3_diff", 32'(diff), 32'h00); check("b2b3_zero", 32'(zero), 32'd1); end
                endcase
                if (ndone > 0) check("b2b_period", 32'(cyc - last_cyc), 32'd9);
                last_cyc = cyc;
                ndone++;
                if (ndone == 4) start = 1'b0;
            end
            if (busy && !prev_busy && k < 4) begin
                a_i = ops_a[k]; b_i = ops_b[k]; bin_i = ops_c[k];
                k++;
            end
            prev_done = done;
            prev_busy = busy;
        end
        start = 1'b0;
        check("b2b_ndone", 32'(ndone), 32'd4);
        tick();

        // Reset at RUN bit 4 abandons the operation.
        start = 1'b1; a_i = 8'h9C; b_i = 8'h15; bin_i = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_diff", 32'(diff), 32'd0);
        check("mrst_bout", 32'(bout), 32'd0);
        check("mrst_zero", 32'(zero), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        check("mrst_nodone", 32'(ndone), 32'd0);
        run_op("opff01b", 8'hFF, 8'h01, 1'b1, 8'hFD, 1'b0, 1'b0);

        // Random operations against an arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'hFF; rc = 1'b1; end
            ed = ra - rb - 8'(rc);
            eb = ({1'b0, ra} < ({1'b0, rb} + 9'(rc)));
            run_op("rnd", ra, rb, rc, ed, eb, ed == 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_subtractor_ctrl
`default_nettype wire

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial multi-bit subtractor controller. Accepts two WIDTH-bit unsigned operands and a borrow-in, then sequences a single 1-bit full-subtractor cell LSB-first over WIDTH cycles, carrying the borrow in a flop. Sits beside the combinational arithmetic cells as the area-minimal path for wide subtraction and comparison, where one cell is time-shared instead of replicated WIDTH times.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low; sampled on rising clk.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; results valid.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin.
- zero  output  1  1 iff diff == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> capture a, b into shift registers, bin into the borrow flop, clear the bit counter -> RUN.
- RUN: each cycle, feed a_sh[0], b_sh[0] and the borrow flop into the cell:
  - shift the cell difference into diff_sh from the MSB side;
  - load the cell borrow into the borrow flop;
  - shift a_sh and b_sh right;
  - increment the counter.
  - After the WIDTH-th bit -> DONE.
- DONE: assert done for this cycle only; diff, bout and zero are valid.
  - start=1 -> accept a new operation as in IDLE, enabling back-to-back operation.
  - Otherwise -> IDLE.
- Outputs diff, bout and zero hold their last values until the next operation completes. They are not cleared on start.
- zero is registered together with diff at the DONE transition. It is computed from the full assembled result.
- start in RUN is ignored. No queuing, no error flag.
- Counter width: clog2(WIDTH)+1 bits. It must not wrap before reaching WIDTH.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, counter=0, borrow flop=0, busy=0, done=0, diff=0, bout=0, zero=0.
  - Takes priority over start and over any in-flight operation.
- Reset mid-RUN: operation abandoned. done never pulses for it, and outputs are zero after that edge.
- Latency:
  - Edge E0 accepts start; busy=1 from E0.
  - Edges E1..EWIDTH process bits 0..WIDTH-1.
  - Cycle after EWIDTH: done=1, busy=0, results valid.
  - Accept-to-done is WIDTH+1 edges, counting the accepting edge as edge 0 and the edge that raises done as edge WIDTH.
- Throughput: one operation per WIDTH+1 cycles with start held high.
- busy and done are never high together. Both are registered: no combinational path from inputs to any output.
- a, b and bin may change freely after the accepting edge.

## Structure
- Shared package/header `subtractor_pkg`: state encoding constants (IDLE, RUN, DONE) and a width-to-counter-bits constant function.
  - Reused by any later serial arithmetic controllers.
- One sub-module, `full_subtractor`: the existing 1-bit cell with ports a, b, Bin, Difference, Bout.
  - Instantiated once, unmodified.
  - All sequencing, shift registers and the borrow flop live in serial_subtractor_ctrl.

## Test plan
(WIDTH=8 for all scenarios.)
- Reset asserted for 2 cycles with start=1 -> all outputs 0 and busy stays 0. After release, start with a=0x5A, b=0x3C, bin=0 -> done on the 8th edge after acceptance, diff=0x1E, bout=0, zero=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, zero=0. Also a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
- a=0x37, b=0x37, bin=0 -> diff=0x00, bout=0, zero=1.
- Start pulsed again 3 cycles into RUN with different operands -> ignored. Result matches the first operands; done pulses exactly once.
- start held high continuously with operands changed on each acceptance -> operations complete every 9 cycles. Each result matches its own operands; done is never high for 2 consecutive cycles.
- rst_n low for one edge at RUN bit 4 -> busy=0 and outputs 0 on the next cycle, no done pulse. A following operation a=0xFF, b=0x01, bin=1 -> diff=0xFD, bout=0.
- Randomized run of 1000 operations checked against (a-b-bin) mod 256 and the borrow.
